// File: rtl/mask_gen_frame.sv
// Frame-level binary mask row generator: sliding-left/right, LFSR random and repeated tile.
// Random mode (32-bit Galois LFSR) is compiled in only when MASK_GEN_LFSR_EN is defined.
module mask_gen_frame #(
    parameter int unsigned ROW_W     = 640,
    parameter int unsigned NUM_ROWS  = 480,
    parameter int unsigned PAT_MAX   = 32,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        start,
    input  logic [1:0]                  mask_type,
    input  logic [$clog2(PAT_MAX)-1:0]  pattern_w,
    input  logic [PAT_MAX-1:0]          pattern,
    output logic [0:ROW_W-1]            mask,
    output logic                        mask_valid,
    input  logic                        mask_ready,
    output logic [$clog2(NUM_ROWS)-1:0] row_idx,
    output logic                        busy,
    output logic                        frame_done
);
    localparam int unsigned PW = $clog2(PAT_MAX);
    localparam int unsigned RW = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;
    state_t state, state_nx;

    logic [1:0]         sh_type;
    logic [PW-1:0]      sh_nm1;
    logic [PAT_MAX-1:0] sh_pat;
    logic [PW-1:0]      phase;
    logic [0:ROW_W-1]   row_nx;
    logic               gen_done;
    logic               last_row;

    assign last_row   = (row_idx == RW'(NUM_ROWS - 1));
    assign mask_valid = (state == HOLD);
    assign busy       = (state != IDLE);

`ifdef MASK_GEN_LFSR_EN
    localparam int unsigned WORDS = ROW_W / 32;
    localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0]    lfsr;
    logic [WCW-1:0] word_cnt;
    logic           rand_mode;

    assign rand_mode = (sh_type == 2'b10);
    assign gen_done  = !rand_mode || (word_cnt == WCW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= LFSR_SEED;
            word_cnt <= '0;
        end else if (clk_en && state == GEN && rand_mode) begin
            lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
            word_cnt <= gen_done ? '0 : word_cnt + 1'b1;
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign gen_done    = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clk_en) begin
            case (state)
                IDLE:    if (start) state_nx = GEN;
                GEN:     if (gen_done) state_nx = HOLD;
                HOLD:    if (mask_ready) state_nx = last_row ? IDLE : GEN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Tile walk: pixel i takes pattern bit (phase + i) mod N; phase tracks the row offset.
    always_comb begin
        logic [PW-1:0] k;
        k      = phase;
        row_nx = '0;
        for (int unsigned i = 0; i < ROW_W; i++) begin
            row_nx[i] = sh_pat[PW'(PAT_MAX - 1) - k];
            k = (k == sh_nm1) ? '0 : k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask       <= '0;
            row_idx    <= '0;
            frame_done <= 1'b0;
            sh_type    <= '0;
            sh_nm1     <= '0;
            sh_pat     <= '0;
            phase      <= '0;
        end else begin
            frame_done <= (state == HOLD) && mask_ready && clk_en && last_row;
            if (clk_en) begin
                case (state)
                    IDLE: if (start) begin
                        sh_type <= mask_type;
                        sh_nm1  <= (pattern_w == '0) ? PW'(PAT_MAX - 1) : pattern_w - 1'b1;
                        sh_pat  <= pattern;
                        row_idx <= '0;
                        phase   <= '0;
                    end
                    GEN: begin
`ifdef MASK_GEN_LFSR_EN
                        // Words shift in from the right so word j lands at pixels 32j..32j+31 after W cycles.
                        if (rand_mode)
                            mask <= (mask << 32) | ROW_W'(lfsr);
                        else
`endif
                        if (sh_type == 2'b10)
                            mask <= '0;
                        else
                            mask <= row_nx;
                    end
                    HOLD: if (mask_ready && !last_row) begin
                        row_idx <= row_idx + 1'b1;
                        case (sh_type)
                            2'b00:   phase <= (phase == sh_nm1) ? '0 : phase + 1'b1;
                            2'b01:   phase <= (phase == '0) ? sh_nm1 : phase - 1'b1;
                            default: phase <= phase;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mask_gen_frame.sv
// Directed self-checking bench for mask_gen_frame at default parameters.
module tb_mask_gen_frame;
    localparam int unsigned ROW_W = 640;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic             start;
    logic [1:0]       mask_type;
    logic [4:0]       pattern_w;
    logic [31:0]      pattern;
    logic [0:ROW_W-1] mask;
    logic             mask_valid;
    logic             mask_ready;
    logic [8:0]       row_idx;
    logic             busy;
    logic             frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    mask_gen_frame #(
        .ROW_W(640),
        .NUM_ROWS(480),
        .PAT_MAX(32),
        .LFSR_SEED(32'h0000_0001)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .start(start),
        .mask_type(mask_type),
        .pattern_w(pattern_w),
        .pattern(pattern),
        .mask(mask),
        .mask_valid(mask_valid),
        .mask_ready(mask_ready),
        .row_idx(row_idx),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_r(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int exp_cyc);
        int n;
        n = 0;
        while (!mask_valid && n < 100) begin
            tick();
            n++;
        end
        chk_i(tag, n, exp_cyc);
    endtask

    task automatic xfer();
        mask_ready = 1'b1;
        tick();
        mask_ready = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [ROW_W-1:0] m;
        int               xfers;
        logic             got_done;
        int               n;

        rst = 1'b1; clk_en = 1'b1; start = 1'b0; mask_ready = 1'b0;
        mask_type = 2'b00; pattern_w = '0; pattern = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_r("rst_mask", mask, '0);
        chk_i("rst_valid", int'(mask_valid), 0);
        chk_i("rst_row", int'(row_idx), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(frame_done), 0);

        // Repeated tile, full frame with ready tied high
        mask_type = 2'b11; pattern_w = 5'd8; pattern = 32'hAF00_0000; mask_ready = 1'b1;
        pulse_start();
        chk_i("rep_busy", int'(busy), 1);
        chk_i("rep_valid_at_start", int'(mask_valid), 0);
        tick();
        chk_i("rep_valid_lat1", int'(mask_valid), 1);
        xfers = 0;
        got_done = 1'b0;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            if (mask_valid) begin
                chk_r("rep_row", mask, {80{8'hAF}});
                chk_i("rep_row_idx", int'(row_idx), xfers);
                xfers++;
            end
            tick();
            if (frame_done) got_done = 1'b1;
        end
        mask_ready = 1'b0;
        chk_i("rep_xfers", xfers, 480);
        chk_i("rep_done", int'(frame_done), 1);
        chk_i("rep_busy_end", int'(busy), 0);
        chk_i("rep_valid_end", int'(mask_valid), 0);
        tick();
        chk_i("rep_done_pulse", int'(frame_done), 0);

        // Sliding-left N=4, single set bit
        mask_type = 2'b00; pattern_w = 5'd4; pattern = 32'h8000_0000;
        pulse_start();
        wait_valid("sl_lat", 1);
        chk_r("sl_row0", mask, {160{4'h8}});
        xfer();
        wait_valid("sl_gap1", 1);
        chk_r("sl_row1", mask, {160{4'h1}});
        chk_i("sl_idx1", int'(row_idx), 1);
        xfer();
        wait_valid("sl_gap2", 1);
        chk_r("sl_row2", mask, {160{4'h2}});
        xfer();
        wait_valid("sl_gap3", 1);
        chk_r("sl_row3", mask, {160{4'h4}});

        // Backpressure at row 3 with a mid-frame start and changed config inputs
        mask_type = 2'b11; pattern_w = '0; pattern = 32'hDEAD_BEEF;
        pulse_start();
        repeat (4) tick();
        chk_r("bp_mask", mask, {160{4'h4}});
        chk_i("bp_row", int'(row_idx), 3);
        chk_i("bp_valid", int'(mask_valid), 1);
        xfer();
        chk_i("bp_valid_after", int'(mask_valid), 0);
        chk_i("bp_row_after", int'(row_idx), 4);
        tick();
        chk_i("bp_row4_valid", int'(mask_valid), 1);
        chk_r("sl_row4", mask, {160{4'h8}});

        // Run to row 100, then reset mid-frame
        mask_ready = 1'b1;
        n = 0;
        while (!(mask_valid && row_idx == 9'd100) && n < 1000) begin
            tick();
            n++;
        end
        mask_ready = 1'b0;
        chk_i("sl_row100_idx", int'(row_idx), 100);
        chk_r("sl_row100", mask, {160{4'h8}});
        do_reset();
        chk_r("mid_rst_mask", mask, '0);
        chk_i("mid_rst_valid", int'(mask_valid), 0);
        chk_i("mid_rst_row", int'(row_idx), 0);
        chk_i("mid_rst_busy", int'(busy), 0);
        chk_i("mid_rst_done", int'(frame_done), 0);

        // Sliding-right N=4
        mask_type = 2'b01; pattern_w = 5'd4; pattern = 32'h8000_0000;
        pulse_start();
        wait_valid("sr_lat", 1);
        chk_r("sr_row0", mask, {160{4'h8}});
        chk_i("sr_idx0", int'(row_idx), 0);
        xfer();
        wait_valid("sr_gap1", 1);
        chk_r("sr_row1", mask, {160{4'h4}});
        xfer();
        wait_valid("sr_gap2", 1);
        chk_r("sr_row2", mask, {160{4'h2}});
        do_reset();

        // N=32 via pattern_w=0, with clk_en low for 3 cycles during GEN
        mask_type = 2'b11; pattern_w = '0; pattern = 32'hDEAD_BEEF;
        pulse_start();
        clk_en = 1'b0;
        repeat (3) tick();
        chk_i("clken_valid_held", int'(mask_valid), 0);
        chk_i("clken_busy_held", int'(busy), 1);
        clk_en = 1'b1;
        wait_valid("clken_lat", 1);
        chk_r("n32_row", mask, {20{32'hDEAD_BEEF}});
        do_reset();

`ifdef MASK_GEN_LFSR_EN
        mask_type = 2'b10;
        pulse_start();
        wait_valid("rnd_lat", 20);
        m = mask;
        chk_i("rnd_w0", m[639 -: 32], 32'h0000_0001);
        chk_i("rnd_w1", m[607 -: 32], 32'h8020_0003);
        xfer();
        wait_valid("rnd_gap", 20);
        do_reset();
        pulse_start();
        wait_valid("rnd_lat_after_rst", 20);
        m = mask;
        chk_i("rnd_w0_after_rst", m[639 -: 32], 32'h0000_0001);
        do_reset();
`else
        mask_type = 2'b10;
        pulse_start();
        wait_valid("rnd_off_lat", 1);
        chk_r("rnd_off_row", mask, '0);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no completion, required summary before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
